if_id_decode: RTL and testbench
===============================

IF_ID_DECODE -- requirements
Module: if_id_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-004 SHALL have port in_ready, output, 1 bit: the stage can accept an instruction this cycle.
REQ-005 SHALL have port in_instr, input, 32 bits: fetched MIPS instruction word.
REQ-006 SHALL have port in_pc4, input, 32 bits: PC+4 of the fetched instruction.
REQ-007 SHALL have port flush, input, 1 bit: discard the held instruction (branch/jump redirect).
REQ-008 SHALL have port out_valid, output, 1 bit: the decoded instruction is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream (extender/ALU) stage accepts this cycle.
REQ-010 SHALL have ports out_opcode (output, 6 bits), out_funct (output, 6 bits), out_rs, out_rt, out_rd and out_shamt (each output, 5 bits): the instruction fields.
REQ-011 SHALL have port out_imm16, output, 16 bits: instr[15:0], which feeds the 16-to-32 extender input.
REQ-012 SHALL have port out_extOp, output, 1 bit: extender control; 1 = sign-extend, 0 = zero-extend.
REQ-013 SHALL have port out_pc4, output, 32 bits: the registered PC+4.
REQ-014 SHALL have port out_illegal, output, 1 bit: the opcode is unsupported.
REQ-015 SHALL have port out_count, output, 16 bits: count of accepted instructions.

Function
REQ-016 SHALL hold a single-entry pipeline register; in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL load the register on an edge where in_valid && in_ready && !flush, setting out_valid=1; latency is 1 cycle from acceptance to out_valid.
REQ-018 SHALL clear out_valid on an edge where out_valid && out_ready is true and no new load occurs.
REQ-019 SHALL hold every output stable while out_valid=1 and out_ready=0 (stall).
REQ-020 SHALL give flush priority: on an edge with flush=1, out_valid goes to 0 and any simultaneous input is dropped, not counted, and not loaded.
REQ-021 SHALL register the decoded outputs, not drive them combinationally from in_instr: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0].
REQ-022 SHALL set out_extOp=1 for opcodes 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw and 0x2B sw.
REQ-023 SHALL set out_extOp=0 for all other opcodes, including 0x0C andi, 0x0D ori and 0x0E xori.
REQ-024 SHALL set out_illegal=1 for any opcode outside {0x00, 0x02, 0x03, those in REQ-022, 0x0C, 0x0D, 0x0E} (plus 0x0F when enabled); an illegal instruction still passes through with out_valid=1.
REQ-025 SHALL increment out_count by 1 on each accepted load and wrap from 0xFFFF to 0x0000; flush SHALL NOT modify out_count.

Reset
REQ-026 SHALL, when rst_n=0 (asynchronously, independent of clk), force out_valid=0, out_count=0, all field outputs to 0, out_pc4=0, out_extOp=0 and out_illegal=0.
REQ-027 SHALL, when reset asserts mid-stall, discard the held instruction; after rst_n deasserts, in_ready=1 and the first edge with in_valid=1 loads normally.

Configuration
REQ-028 SHALL, when macro IF_ID_LUI_EN is defined, treat opcode 0x0F (lui) as legal with out_extOp=0 and add output port out_lui (1 bit, registered, 1 only for lui, reset 0).
REQ-029 SHALL, when IF_ID_LUI_EN is undefined, omit out_lui and report opcode 0x0F as out_illegal=1 with out_extOp=0.

Verification
REQ-030 SHALL cover: reset release, then in_instr=0x2128FFFF (addi) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, opcode=0x08, rs=9, rt=8, imm16=0xFFFF, extOp=1, illegal=0, count=1.
REQ-031 SHALL cover: in_instr=0x3508FF00 (ori) -> opcode=0x0D, imm16=0xFF00, extOp=0.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, count unchanged; on release the next instruction loads one cycle later.
REQ-033 SHALL cover: flush=1 on the same edge as in_valid=1 -> out_valid=0 and count unchanged.
REQ-034 SHALL cover: 0x3C01ABCD (lui) -> with IF_ID_LUI_EN: out_lui=1, illegal=0, extOp=0; without it: illegal=1; opcode 0x3F -> illegal=1.
REQ-035 SHALL cover: count preloaded to 0xFFFF by 65535 accepts, then one more accept -> count=0x0000; rst_n pulse mid-stall -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_decode.sv
// if_id_decode: single-entry IF/ID pipeline register with MIPS field decode.
// Holds one fetched instruction with valid/ready handshaking. It registers the
// instruction fields, the extender control (sign vs. zero) and an illegal-opcode
// flag. It also counts accepted instructions, and flush discards the held entry.
// Optional feature: define IF_ID_LUI_EN to accept lui (0x0F) as a legal opcode
// and add the registered out_lui output.
module if_id_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc4,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opcode,
    output logic [5:0]  out_funct,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [15:0] out_imm16,
    output logic        out_extOp,
    output logic [31:0] out_pc4,
    output logic        out_illegal,
`ifdef IF_ID_LUI_EN
    output logic        out_lui,
`endif
    output logic [15:0] out_count
);

    logic        valid_q,   valid_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] pc4_q,     pc4_d;
    logic        extop_q,   extop_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q,   count_d;
`ifdef IF_ID_LUI_EN
    logic        lui_q,     lui_d;
    logic        dec_lui;
`endif

    logic        load;
    logic        dec_extop;
    logic        dec_legal;

    assign in_ready = !valid_q || out_ready;
    // A flush on the same edge drops the incoming instruction entirely.
    assign load     = in_valid && in_ready && !flush;

    // Opcode classification for the incoming instruction word.
    always_comb begin
        dec_extop = 1'b0;
        dec_legal = 1'b0;
`ifdef IF_ID_LUI_EN
        dec_lui   = 1'b0;
`endif
        case (in_instr[31:26])
            6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                dec_extop = 1'b1;
                dec_legal = 1'b1;
            end
            6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E: begin
                dec_legal = 1'b1;
            end
`ifdef IF_ID_LUI_EN
            6'h0F: begin
                dec_legal = 1'b1;
                dec_lui   = 1'b1;
            end
`endif
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state for the pipeline register and the accept counter.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        extop_d   = extop_q;
        illegal_d = illegal_q;
        count_d   = count_q;
`ifdef IF_ID_LUI_EN
        lui_d     = lui_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = in_instr;
            pc4_d     = in_pc4;
            extop_d   = dec_extop;
            illegal_d = !dec_legal;
            count_d   = count_q + 16'd1;
`ifdef IF_ID_LUI_EN
            lui_d     = dec_lui;
`endif
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset clears the held entry and every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= 32'd0;
            pc4_q     <= 32'd0;
            extop_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 16'd0;
`ifdef IF_ID_LUI_EN
            lui_q     <= 1'b0;
`endif
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            extop_q   <= extop_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
`ifdef IF_ID_LUI_EN
            lui_q     <= lui_d;
`endif
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = instr_q[31:26];
    assign out_rs      = instr_q[25:21];
    assign out_rt      = instr_q[20:16];
    assign out_rd      = instr_q[15:11];
    assign out_shamt   = instr_q[10:6];
    assign out_funct   = instr_q[5:0];
    assign out_imm16   = instr_q[15:0];
    assign out_extOp   = extop_q;
    assign out_pc4     = pc4_q;
    assign out_illegal = illegal_q;
    assign out_count   = count_q;
`ifdef IF_ID_LUI_EN
    assign out_lui     = lui_q;
`endif

endmodule

// File: tb/tb_if_id_decode.sv
// Directed bench for if_id_decode. Inputs change 1 time unit after the rising
// edge, and outputs are sampled at that same point.
module tb_if_id_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [15:0] out_imm16;
    logic        out_extOp;
    logic [31:0] out_pc4;
    logic        out_illegal;
`ifdef IF_ID_LUI_EN
    logic        out_lui;
`endif
    logic [15:0] out_count;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    if_id_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs),
        .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm16(out_imm16), .out_extOp(out_extOp), .out_pc4(out_pc4),
        .out_illegal(out_illegal),
`ifdef IF_ID_LUI_EN
        .out_lui(out_lui),
`endif
        .out_count(out_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc4 = 32'h0;
        flush = 1'b0; out_ready = 1'b1;
        #2;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests++; if (out_count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h want 0000", out_count); end
        tests++; if ({out_opcode, out_rs, out_rt, out_imm16, out_pc4, out_extOp, out_illegal} !== '0)
            begin fails++; $display("FAIL reset_fields: nonzero field outputs"); end
`ifdef IF_ID_LUI_EN
        tests++; if (out_lui !== 1'b0) begin fails++; $display("FAIL reset_lui: got %b want 0", out_lui); end
`endif
        step(); step();
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'h2128FFFF; in_pc4 = 32'h0000_0104;
        step(); exp_count++;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        tests++; if (out_opcode !== 6'h08) begin fails++; $display("FAIL addi_opcode: got %h want 08", out_opcode); end
        tests++; if (out_rs !== 5'd9 || out_rt !== 5'd8) begin fails++; $display("FAIL addi_rs_rt: got %0d/%0d want 9/8", out_rs, out_rt); end
        tests++; if (out_rd !== 5'd31 || out_shamt !== 5'd31 || out_funct !== 6'h3F)
            begin fails++; $display("FAIL addi_rd_shamt_funct: got %0d/%0d/%h want 31/31/3f", out_rd, out_shamt, out_funct); end
        tests++; if (out_imm16 !== 16'hFFFF) begin fails++; $display("FAIL addi_imm: got %h want ffff", out_imm16); end
        tests++; if (out_extOp !== 1'b1 || out_illegal !== 1'b0) begin fails++; $display("FAIL addi_ext_ill: got %b/%b want 1/0", out_extOp, out_illegal); end
        tests++; if (out_pc4 !== 32'h0000_0104) begin fails++; $display("FAIL addi_pc4: got %h want 00000104", out_pc4); end
        tests++; if (out_count !== 16'd1) begin fails++; $display("FAIL addi_count: got %h want 0001", out_count); end
    endtask

    task automatic test_ori();
        in_instr = 32'h3508FF00; in_pc4 = 32'h0000_0108;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h0D || out_imm16 !== 16'hFF00)
            begin fails++; $display("FAIL ori_fields: got %h/%h want 0d/ff00", out_opcode, out_imm16); end
        tests++; if (out_extOp !== 1'b0 || out_illegal !== 1'b0) begin fails++; $display("FAIL ori_ext_ill: got %b/%b want 0/0", out_extOp, out_illegal); end
        tests++; if (out_count !== exp_count) begin fails++; $display("FAIL ori_count: got %h want %h", out_count, exp_count); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_instr = 32'h8D090004; in_pc4 = 32'h0000_010C;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_opcode !== 6'h0D || out_imm16 !== 16'hFF00 || out_pc4 !== 32'h0000_0108)
                begin fails++; $display("FAIL stall_hold%0d: got rdy=%b v=%b op=%h imm=%h want 0/1/0d/ff00", i, in_ready, out_valid, out_opcode, out_imm16); end
            tests++; if (out_count !== exp_count) begin fails++; $display("FAIL stall_count%0d: got %h want %h", i, out_count, exp_count); end
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", in_ready); end
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h23 || out_extOp !== 1'b1 || out_imm16 !== 16'h0004 || out_pc4 !== 32'h0000_010C)
            begin fails++; $display("FAIL release_lw: got op=%h ext=%b imm=%h want 23/1/0004", out_opcode, out_extOp, out_imm16); end
        tests++; if (out_count !== exp_count) begin fails++; $display("FAIL release_count: got %h want %h", out_count, exp_count); end
    endtask

    task automatic test_flush();
        in_instr = 32'h11000003; flush = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        tests++; if (out_count !== exp_count) begin fails++; $display("FAIL flush_count: got %h want %h", out_count, exp_count); end
        flush = 1'b0; in_valid = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_idle: got %b want 0", out_valid); end
        in_valid = 1'b1;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h04 || out_extOp !== 1'b1 || out_illegal !== 1'b0 || out_valid !== 1'b1)
            begin fails++; $display("FAIL beq: got op=%h ext=%b ill=%b want 04/1/0", out_opcode, out_extOp, out_illegal); end
    endtask

    task automatic test_opcodes();
        in_instr = 32'h3C01ABCD;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h0F || out_extOp !== 1'b0 || out_imm16 !== 16'hABCD)
            begin fails++; $display("FAIL lui_fields: got op=%h ext=%b imm=%h want 0f/0/abcd", out_opcode, out_extOp, out_imm16); end
`ifdef IF_ID_LUI_EN
        tests++; if (out_lui !== 1'b1 || out_illegal !== 1'b0) begin fails++; $display("FAIL lui_flags: got lui=%b ill=%b want 1/0", out_lui, out_illegal); end
`else
        tests++; if (out_illegal !== 1'b1) begin fails++; $display("FAIL lui_illegal: got %b want 1", out_illegal); end
`endif
        in_instr = 32'hFC000000;
        step(); exp_count++;
        tests++; if (out_illegal !== 1'b1 || out_valid !== 1'b1 || out_extOp !== 1'b0)
            begin fails++; $display("FAIL op3f: got ill=%b v=%b ext=%b want 1/1/0", out_illegal, out_valid, out_extOp); end
`ifdef IF_ID_LUI_EN
        tests++; if (out_lui !== 1'b0) begin fails++; $display("FAIL op3f_lui: got %b want 0", out_lui); end
`endif
        in_instr = 32'h0C000010;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h03 || out_illegal !== 1'b0 || out_extOp !== 1'b0)
            begin fails++; $display("FAIL jal: got op=%h ill=%b ext=%b want 03/0/0", out_opcode, out_illegal, out_extOp); end
        in_instr = 32'h3128000F;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h0C || out_illegal !== 1'b0 || out_extOp !== 1'b0)
            begin fails++; $display("FAIL andi: got op=%h ill=%b ext=%b want 0c/0/0", out_opcode, out_illegal, out_extOp); end
        in_instr = 32'hAD090008;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h2B || out_illegal !== 1'b0 || out_extOp !== 1'b1)
            begin fails++; $display("FAIL sw: got op=%h ill=%b ext=%b want 2b/0/1", out_opcode, out_illegal, out_extOp); end
        in_instr = 32'h01095020;
        step(); exp_count++;
        tests++; if (out_opcode !== 6'h00 || out_rd !== 5'd10 || out_funct !== 6'h20 || out_illegal !== 1'b0 || out_extOp !== 1'b0)
            begin fails++; $display("FAIL add_r: got op=%h rd=%0d fn=%h ill=%b want 00/10/20/0", out_opcode, out_rd, out_funct, out_illegal); end
        tests++; if (out_count !== exp_count) begin fails++; $display("FAIL opcode_count: got %h want %h", out_count, exp_count); end
    endtask

    task automatic test_wrap();
        int n;
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h20000001;
        n = 32'hFFFF - int'(exp_count);
        for (int i = 0; i < n; i++) step();
        tests++; if (out_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %h want ffff", out_count); end
        step();
        tests++; if (out_count !== 16'h0000) begin fails++; $display("FAIL wrap: got %h want 0000", out_count); end
        exp_count = 16'h0000;
    endtask

    task automatic test_reset_stall();
        in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h2128FFFF;
        step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rs_stall_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_count !== 16'h0 || out_opcode !== 6'h0)
            begin fails++; $display("FAIL rs_async: got v=%b cnt=%h op=%h want 0/0000/00", out_valid, out_count, out_opcode); end
        #2 rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rs_ready: got %b want 1", in_ready); end
        in_instr = 32'h3508FF00;
        step();
        tests++; if (out_valid !== 1'b1 || out_count !== 16'd1 || out_opcode !== 6'h0D)
            begin fails++; $display("FAIL rs_reload: got v=%b cnt=%h op=%h want 1/0001/0d", out_valid, out_count, out_opcode); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ori();
        test_stall();
        test_flush();
        test_opcodes();
        test_wrap();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
